// File: rtl/fft_seq_pkg.sv
// Shared types for the in-place radix-2 DIF FFT sequencer: FSM states,
// address widths and the butterfly pair-address record.
package fft_seq_pkg;

  // Build-time maximum transform size (log2). The pair record is sized from it,
  // so the sequencer's MAX_STAGES parameter should track this value.
  localparam int MAX_STAGES_DEF = 10;
  localparam int ADDR_W         = MAX_STAGES_DEF;      // sample address width
  localparam int PAIR_W         = MAX_STAGES_DEF - 1;  // butterflies per stage need N/2 codes

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
  } pair_addr_t;

  // A run needs at least two stages and must fit in the sample memory.
  function automatic logic size_ok(input int n, input int max_stages);
    return (n >= 2) && (n <= max_stages);
  endfunction

endpackage

// File: rtl/fft_inplace_sequencer_if.sv
// Datapath-side bus of the FFT sequencer: sample BRAM port B, twiddle ROM
// address and the processing-element handshake. master = sequencer.
interface fft_inplace_sequencer_if #(
  parameter int MAX_STAGES = 10,
  parameter int SHAMT_BITS = 4
);
  logic                  mem_rd_en_o;
  logic [MAX_STAGES-1:0] mem_rd_addr0_o;
  logic [MAX_STAGES-1:0] mem_rd_addr1_o;
  logic [MAX_STAGES-2:0] tw_addr_o;
  logic                  pe_valid_o;
  logic [SHAMT_BITS-1:0] pe_shamt_o;
  logic                  pe_ready_i;
  logic                  res_valid_i;
  logic                  res_ovf_i;
  logic                  mem_wr_en_o;
  logic [MAX_STAGES-1:0] mem_wr_addr0_o;
  logic [MAX_STAGES-1:0] mem_wr_addr1_o;

  modport master (
    output mem_rd_en_o, mem_rd_addr0_o, mem_rd_addr1_o, tw_addr_o,
    output pe_valid_o, pe_shamt_o, mem_wr_en_o, mem_wr_addr0_o, mem_wr_addr1_o,
    input  pe_ready_i, res_valid_i, res_ovf_i
  );

  modport slave (
    input  mem_rd_en_o, mem_rd_addr0_o, mem_rd_addr1_o, tw_addr_o,
    input  pe_valid_o, pe_shamt_o, mem_wr_en_o, mem_wr_addr0_o, mem_wr_addr1_o,
    output pe_ready_i, res_valid_i, res_ovf_i
  );
endinterface

// File: rtl/fft_addr_fifo.sv
// In-order FIFO of butterfly pair addresses awaiting write-back. The head is
// read combinationally so a returning result can write in the same cycle.
module fft_addr_fifo
  import fft_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pair_addr_t             din_i,
  output pair_addr_t             head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pair_addr_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i && (r_count != CNT_W'(DEPTH));
  assign w_pop   = pop_i && (r_count != '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  // Storage write and pointer/occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fft_inplace_sequencer.sv
// Control engine for an in-place radix-2 DIF FFT: generates butterfly pair
// and twiddle addresses, bounds in-flight butterflies, enforces a barrier
// between stages and tracks block-floating-point scaling.
// Optional: define FFT_CYCLE_COUNT_EN to add cycle_count_o (busy-cycle counter).
module fft_inplace_sequencer
  import fft_seq_pkg::*;
#(
  parameter int MAX_STAGES = MAX_STAGES_DEF,
  parameter int STAGE_BITS = 4,
  parameter int SHAMT_BITS = 4,
  parameter int MAX_SHIFTS = 8,
  parameter int INFLIGHT   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [STAGE_BITS-1:0] log2n_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o,
  output logic [MAX_SHIFTS-1:0] total_shifts_o,
`ifdef FFT_CYCLE_COUNT_EN
  output logic [31:0]           cycle_count_o,
`endif
  fft_inplace_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(INFLIGHT) + 1;
  localparam int TW_W  = MAX_STAGES - 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [STAGE_BITS-1:0] r_n;
  logic [STAGE_BITS-1:0] r_s;
  logic [MAX_STAGES-1:0] r_p;
  logic                  r_shift;
  logic                  r_ovf_seen;
  logic                  r_cfg_err;
  logic [MAX_SHIFTS-1:0] r_total_shifts;
  logic                  r_pe_valid;
  logic [TW_W-1:0]       r_tw;
  logic [SHAMT_BITS-1:0] r_shamt;

  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_issue;
  logic                  w_last_pair;
  logic                  w_last_stage;
  logic                  w_drained;
  logic                  w_stage_adv;
  logic                  w_pop;
  logic                  w_res_err;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [STAGE_BITS-1:0] w_span_sh;
  logic [MAX_STAGES-1:0] w_span;
  logic [MAX_STAGES-1:0] w_idx0;
  logic [MAX_STAGES-1:0] w_idx1;
  logic [TW_W-1:0]       w_tw;
  pair_addr_t            w_push_pair;
  pair_addr_t            w_head;

  assign w_start_ok  = (r_state == IDLE) && start_i && size_ok(int'(log2n_i), MAX_STAGES);
  assign w_start_bad = (r_state == IDLE) && start_i && !size_ok(int'(log2n_i), MAX_STAGES);

  // span = N >> (s+1) = 2^(n-1-s); p's low bits select within a group,
  // its high bits select the group (groups are 2*span apart).
  assign w_span_sh = r_n - r_s - STAGE_BITS'(1);
  assign w_span    = MAX_STAGES'(1) << w_span_sh;
  assign w_idx0    = ((r_p >> w_span_sh) << (w_span_sh + STAGE_BITS'(1)))
                   | (r_p & (w_span - MAX_STAGES'(1)));
  assign w_idx1    = w_idx0 + w_span;
  // Twiddle index is scaled to the full-size ROM so smaller N reuse it.
  assign w_tw      = TW_W'(((r_p & (w_span - MAX_STAGES'(1))) << r_s)
                           << (STAGE_BITS'(MAX_STAGES) - r_n));

  assign w_last_pair  = (r_p == ((MAX_STAGES'(1) << (r_n - STAGE_BITS'(1))) - MAX_STAGES'(1)));
  assign w_last_stage = (r_s == r_n - STAGE_BITS'(1));
  assign w_drained    = (w_fifo_count == '0);
  assign w_stage_adv  = (r_state == DRAIN) && w_drained && !w_last_stage;
  assign w_issue      = (r_state == ISSUE) && bus.pe_ready_i && (w_fifo_count < CNT_W'(INFLIGHT));
  assign w_pop        = bus.res_valid_i && !w_fifo_empty;
  assign w_res_err    = bus.res_valid_i && w_fifo_empty;
  assign w_push_pair  = '{addr0: w_idx0, addr1: w_idx1};

  fft_addr_fifo #(
    .DEPTH (INFLIGHT)
  ) u_addr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_issue),
    .pop_i   (w_pop),
    .din_i   (w_push_pair),
    .head_o  (w_head),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: issue a stage, drain it to the barrier, repeat, finish.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = ISSUE;
      ISSUE:   if (w_issue && w_last_pair) w_state_next = DRAIN;
      DRAIN:   if (w_drained) w_state_next = w_last_stage ? DONE : ISSUE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs and bus drive; idle address lines are held at zero.
  always_comb begin
    busy_o             = (r_state != IDLE);
    done_o             = (r_state == DONE);
    cfg_err_o          = r_cfg_err;
    total_shifts_o     = r_total_shifts;
    bus.mem_rd_en_o    = w_issue;
    bus.mem_rd_addr0_o = w_issue ? w_idx0 : '0;
    bus.mem_rd_addr1_o = w_issue ? w_idx1 : '0;
    bus.pe_valid_o     = r_pe_valid;
    bus.tw_addr_o      = r_tw;
    bus.pe_shamt_o     = r_shamt;
    bus.mem_wr_en_o    = w_pop;
    bus.mem_wr_addr0_o = w_pop ? w_head.addr0 : '0;
    bus.mem_wr_addr1_o = w_pop ? w_head.addr1 : '0;
  end

  // Run bookkeeping: size latch, stage/pair counters, scaling, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_n            <= '0;
      r_s            <= '0;
      r_p            <= '0;
      r_shift        <= 1'b0;
      r_ovf_seen     <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_total_shifts <= '0;
    end else begin
      if (w_start_bad || w_res_err) r_cfg_err <= 1'b1;
      if (w_pop && bus.res_ovf_i) r_ovf_seen <= 1'b1;
      if ((r_state == IDLE) && start_i) r_n <= log2n_i;
      if (w_start_ok) begin
        r_s            <= '0;
        r_p            <= '0;
        r_shift        <= 1'b0;
        r_ovf_seen     <= 1'b0;
        r_total_shifts <= '0;
      end
      if (w_issue) r_p <= r_p + 1'b1;
      // Stage boundary: all results of stage s are back, so ovf_seen is final.
      if (w_stage_adv) begin
        r_s        <= r_s + 1'b1;
        r_p        <= '0;
        r_shift    <= r_ovf_seen;
        r_ovf_seen <= 1'b0;
        if (r_ovf_seen && (r_total_shifts != '1))
          r_total_shifts <= r_total_shifts + 1'b1;
      end
    end
  end

  // PE-side sideband registered to line up with BRAM read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pe_valid <= 1'b0;
      r_tw       <= '0;
      r_shamt    <= '0;
    end else begin
      r_pe_valid <= w_issue;
      r_tw       <= w_issue ? w_tw : '0;
      r_shamt    <= w_issue ? {{(SHAMT_BITS-1){1'b0}}, r_shift} : '0;
    end
  end

`ifdef FFT_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  // Busy-cycle counter: cleared on accepted start, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 r_cycle_count <= '0;
    else if (w_start_ok)                       r_cycle_count <= '0;
    else if (busy_o && (r_cycle_count != '1))  r_cycle_count <= r_cycle_count + 1'b1;
  end

  assign cycle_count_o = r_cycle_count;
`endif

endmodule
